// File: rtl/tree_walk_classifier.sv
// Decision-tree packet classifier: walks a software-programmed node memory from
// node 0 until it reaches a leaf, a miss, an error or the step limit, then holds
// the result on a valid/ready output and keeps saturating lookup/hit counters.

package tree_walk_classifier_pkg;

   localparam int unsigned NumRules    = 2;
   localparam int unsigned NumChildren = 4;

   typedef struct packed {
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [7:0]  proto;
   } packet_s;

   // Masked match on IPs and protocol, inclusive range on destination port.
   typedef struct packed {
      logic        valid;
      logic [31:0] src_ip;
      logic [31:0] src_msk;
      logic [31:0] dst_ip;
      logic [31:0] dst_msk;
      logic [15:0] dport_lo;
      logic [15:0] dport_hi;
      logic [7:0]  proto;
      logic [7:0]  proto_msk;
   } rule_s;

   // Child addresses are wider than the node memory so software mistakes are caught.
   typedef struct packed {
      logic        valid;
      logic [15:0] addr;
   } child_s;

   typedef enum logic [1:0] {
      NodeLeaf      = 2'd0,
      NodeCut       = 2'd1,
      NodePartition = 2'd2,
      NodeRsvd      = 2'd3
   } node_type_e;

   // cut_field: 0 src_ip, 1 dst_ip, 2 src_port, 3 dst_port, 4 proto.
   // cut_bits: number of field bits (0..2) forming the child index.
   typedef struct packed {
      node_type_e                  node_type;
      logic [2:0]                  cut_field;
      logic [4:0]                  cut_shift;
      logic [1:0]                  cut_bits;
      child_s [NumChildren-1:0]    children;
      rule_s  [NumRules-1:0]       rules;
   } node_s;

   localparam logic [1:0] ErrOk        = 2'd0;
   localparam logic [1:0] ErrPartition = 2'd1;
   localparam logic [1:0] ErrTimeout   = 2'd2;
   localparam logic [1:0] ErrRange     = 2'd3;

endpackage

module tree_walk_classifier
   import tree_walk_classifier_pkg::*;
#(
   parameter int unsigned NODE_AW   = 10,
   parameter int unsigned MAX_STEPS = 16,
   parameter int unsigned CNT_W     = 32
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  packet_s            in_pkt_i,
   input  logic               cfg_we_i,
   input  logic [NODE_AW-1:0] cfg_addr_i,
   input  node_s              cfg_wdata_i,
   output logic               cfg_ready_o,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic               out_hit_o,
   output rule_s              out_rule_o,
   output logic [NODE_AW-1:0] out_node_o,
   output logic [1:0]         out_err_o,
   output logic [CNT_W-1:0]   cnt_lookups_o,
   output logic [CNT_W-1:0]   cnt_hits_o
);

   localparam int unsigned Depth    = 2 ** NODE_AW;
   localparam int unsigned StepW    = $clog2(MAX_STEPS + 1);
   localparam int unsigned RuleIdxW = $clog2(NumRules);
   localparam int unsigned ChildIdxW = $clog2(NumChildren);

   typedef enum logic [1:0] {StIdle, StFetch, StEval, StDone} state_e;

   state_e               state_q, state_d;
   logic [StepW-1:0]     steps_q, steps_d, steps_inc;
   packet_s              pkt_q, pkt_d;
   node_s                cur_node_q, cur_node_d;
   logic [NODE_AW-1:0]   cur_idx_q, cur_idx_d;
   logic [NODE_AW-1:0]   rd_idx_q, rd_idx_d;
   logic                 out_hit_q, out_hit_d;
   rule_s                out_rule_q, out_rule_d;
   logic [NODE_AW-1:0]   out_node_q, out_node_d;
   logic [1:0]           out_err_q, out_err_d;
   logic [CNT_W-1:0]     cnt_lookups_q, cnt_lookups_d;
   logic [CNT_W-1:0]     cnt_hits_q, cnt_hits_d;

   node_s                mem_q [Depth];
   node_s                mem_rdata_q;
   logic                 mem_we, mem_re;
   logic [NODE_AW-1:0]   mem_addr;

   logic                 found_rule;
   logic [RuleIdxW-1:0]  rule_index;
   logic                 found_child;
   logic                 child_in_range;
   logic [ChildIdxW-1:0] child_index;
   logic [31:0]          cut_value;
   child_s               child;

   logic                 eval_done;
   logic                 eval_hit;
   logic [1:0]           eval_err;
   rule_s                eval_rule;

   function automatic logic rule_match(input packet_s p, input rule_s r);
      return r.valid
         && ((p.src_ip & r.src_msk) == (r.src_ip & r.src_msk))
         && ((p.dst_ip & r.dst_msk) == (r.dst_ip & r.dst_msk))
         && (p.dst_port >= r.dport_lo) && (p.dst_port <= r.dport_hi)
         && ((p.proto & r.proto_msk) == (r.proto & r.proto_msk));
   endfunction

   // Node memory: the single port is a write only when software owns it in IDLE.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_q[mem_addr] <= cfg_wdata_i;
      end else if (mem_re) begin
         mem_rdata_q <= mem_q[mem_addr];
      end
   end

   // leaf_match: lowest-index matching rule of the current node wins.
   always_comb begin
      found_rule = 1'b0;
      rule_index = '0;
      for (int i = NumRules - 1; i >= 0; i--) begin
         if (rule_match(pkt_q, cur_node_q.rules[i])) begin
            found_rule = 1'b1;
            rule_index = RuleIdxW'(i);
         end
      end
   end

   // cut_match: slice the selected header field to pick a child slot.
   always_comb begin
      unique case (cur_node_q.cut_field)
         3'd0:    cut_value = pkt_q.src_ip;
         3'd1:    cut_value = pkt_q.dst_ip;
         3'd2:    cut_value = {16'd0, pkt_q.src_port};
         3'd3:    cut_value = {16'd0, pkt_q.dst_port};
         3'd4:    cut_value = {24'd0, pkt_q.proto};
         default: cut_value = 32'd0;
      endcase
      unique case (cur_node_q.cut_bits)
         2'd0:    child_index = '0;
         2'd1:    child_index = ChildIdxW'(cut_value >> cur_node_q.cut_shift) & 2'b01;
         default: child_index = ChildIdxW'(cut_value >> cur_node_q.cut_shift);
      endcase
      child          = cur_node_q.children[child_index];
      found_child    = child.valid;
      child_in_range = (({16'd0, child.addr}) >> NODE_AW) == 32'd0;
   end

   // Walk FSM next-state, memory control, handshakes and result capture.
   always_comb begin
      state_d       = state_q;
      steps_d       = steps_q;
      pkt_d         = pkt_q;
      cur_node_d    = cur_node_q;
      cur_idx_d     = cur_idx_q;
      rd_idx_d      = rd_idx_q;
      out_hit_d     = out_hit_q;
      out_rule_d    = out_rule_q;
      out_node_d    = out_node_q;
      out_err_d     = out_err_q;
      cnt_lookups_d = cnt_lookups_q;
      cnt_hits_d    = cnt_hits_q;
      mem_we        = 1'b0;
      mem_re        = 1'b0;
      mem_addr      = '0;
      in_ready_o    = 1'b0;
      cfg_ready_o   = 1'b0;
      out_valid_o   = 1'b0;
      steps_inc     = steps_q + StepW'(1);
      eval_done     = 1'b0;
      eval_hit      = 1'b0;
      eval_err      = ErrOk;
      eval_rule     = '0;

      unique case (state_q)
         StIdle: begin
            cfg_ready_o = 1'b1;
            in_ready_o  = !cfg_we_i;
            if (cfg_we_i) begin
               mem_we   = 1'b1;
               mem_addr = cfg_addr_i;
            end else if (in_valid_i) begin
               pkt_d    = in_pkt_i;
               mem_re   = 1'b1;
               mem_addr = '0;
               rd_idx_d = '0;
               steps_d  = '0;
               state_d  = StFetch;
            end
         end

         StFetch: begin
            cur_node_d = mem_rdata_q;
            cur_idx_d  = rd_idx_q;
            state_d    = StEval;
         end

         StEval: begin
            steps_d = steps_inc;
            if (steps_inc == StepW'(MAX_STEPS)) begin
               eval_done = 1'b1;
               eval_err  = ErrTimeout;
            end else if (cur_node_q.node_type == NodeCut) begin
               if (found_child) begin
                  if (!child_in_range) begin
                     eval_done = 1'b1;
                     eval_err  = ErrRange;
                  end else begin
                     mem_re   = 1'b1;
                     mem_addr = NODE_AW'(child.addr);
                     rd_idx_d = NODE_AW'(child.addr);
                     state_d  = StFetch;
                  end
               end else begin
                  eval_done = 1'b1;
               end
            end else if (cur_node_q.node_type == NodeLeaf) begin
               eval_done = 1'b1;
               eval_hit  = found_rule;
               eval_rule = found_rule ? cur_node_q.rules[rule_index] : '0;
            end else begin
               // Partition nodes are not walkable here; reserved encodings alike.
               eval_done = 1'b1;
               eval_err  = ErrPartition;
            end
            if (eval_done) begin
               out_hit_d  = eval_hit;
               out_rule_d = eval_rule;
               out_node_d = cur_idx_q;
               out_err_d  = eval_err;
               state_d    = StDone;
            end
         end

         StDone: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               if (cnt_lookups_q != {CNT_W{1'b1}}) begin
                  cnt_lookups_d = cnt_lookups_q + CNT_W'(1);
               end
               if (out_hit_q && (cnt_hits_q != {CNT_W{1'b1}})) begin
                  cnt_hits_d = cnt_hits_q + CNT_W'(1);
               end
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset discards any walk in flight.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q       <= StIdle;
         steps_q       <= '0;
         pkt_q         <= '0;
         cur_node_q    <= '0;
         cur_idx_q     <= '0;
         rd_idx_q      <= '0;
         out_hit_q     <= 1'b0;
         out_rule_q    <= '0;
         out_node_q    <= '0;
         out_err_q     <= ErrOk;
         cnt_lookups_q <= '0;
         cnt_hits_q    <= '0;
      end else begin
         state_q       <= state_d;
         steps_q       <= steps_d;
         pkt_q         <= pkt_d;
         cur_node_q    <= cur_node_d;
         cur_idx_q     <= cur_idx_d;
         rd_idx_q      <= rd_idx_d;
         out_hit_q     <= out_hit_d;
         out_rule_q    <= out_rule_d;
         out_node_q    <= out_node_d;
         out_err_q     <= out_err_d;
         cnt_lookups_q <= cnt_lookups_d;
         cnt_hits_q    <= cnt_hits_d;
      end
   end

   assign out_hit_o     = out_hit_q;
   assign out_rule_o    = out_rule_q;
   assign out_node_o    = out_node_q;
   assign out_err_o     = out_err_q;
   assign cnt_lookups_o = cnt_lookups_q;
   assign cnt_hits_o    = cnt_hits_q;

endmodule
